// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Purpose:
//   Shares one external signed 8x8 multiplier between two requesters. A
//   round-robin arbiter picks a requester, latches its operands, starts the
//   multiplier, waits for it to go busy and then ready again, and returns the
//   product. A watchdog aborts an operation that does not finish within
//   TIMEOUT cycles.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   i_req[1:0]       level requests, bit n = requester n
//   i_mp0/i_mc0      requester 0 multiplier / multiplicand (signed 8-bit)
//   i_mp1/i_mc1      requester 1 multiplier / multiplicand (signed 8-bit)
//   o_ack[1:0]       one-hot pulse: request accepted, operands latched
//   o_done[1:0]      one-hot pulse: o_product valid for that requester
//   o_err[1:0]       one-hot pulse: that requester's operation timed out
//   o_product[15:0]  signed product, held until the next o_done
//   o_busy           high in any state other than IDLE
//   o_owner          current or last granted requester
//   o_mult_start     start strobe to the multiplier
//   o_mult_mp/mc     latched operands to the multiplier
//   i_mult_rdy       multiplier ready (low while computing)
//   i_mult_product   multiplier signed product
//   o_state[2:0]     debug view of the FSM state register
//
// Handshakes:
//   Requester side: i_req is a level request; the operation is accepted in the
//   cycle o_ack[n] pulses, and the operands are captured on the edge that
//   raises o_ack, so i_req and operands may change freely afterwards. The
//   operation ends with exactly one pulse on o_done[n] or o_err[n].
//   Multiplier side: o_mult_start pulses for one cycle; completion is the
//   multiplier dropping i_mult_rdy and later raising it again. A high
//   i_mult_rdy before it has been seen low is not a completion.
// -----------------------------------------------------------------------------
module mult_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_req,
    input  logic [7:0]  i_mp0,
    input  logic [7:0]  i_mc0,
    input  logic [7:0]  i_mp1,
    input  logic [7:0]  i_mc1,
    output logic [1:0]  o_ack,
    output logic [1:0]  o_done,
    output logic [1:0]  o_err,
    output logic [15:0] o_product,
    output logic        o_busy,
    output logic        o_owner,
    output logic        o_mult_start,
    output logic [7:0]  o_mult_mp,
    output logic [7:0]  o_mult_mc,
    input  logic        i_mult_rdy,
    input  logic [15:0] i_mult_product,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DONE      = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    // The counter holds the number of wait cycles already spent; the cycle in
    // which it equals TIMEOUT-1 is the last allowed one, so the abort lands
    // exactly TIMEOUT cycles after entering WAIT_BUSY.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          grant;
    logic          timeout_hit;

    function automatic logic [1:0] onehot(input logic idx);
        onehot = idx ? 2'b10 : 2'b01;
    endfunction

    // Round robin: a lone requester always wins, a tie goes to the requester
    // that did not win last time.
    always_comb begin
        grant = 1'b0;
        if (i_req == 2'b11) begin
            grant = ~last_grant;
        end else if (i_req[1]) begin
            grant = 1'b1;
        end
    end

    assign timeout_hit = (cnt == CNT_LAST);
    assign o_state     = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            last_grant   <= 1'b1;
            o_ack        <= '0;
            o_done       <= '0;
            o_err        <= '0;
            o_product    <= '0;
            o_busy       <= 1'b0;
            o_owner      <= 1'b0;
            o_mult_start <= 1'b0;
            o_mult_mp    <= '0;
            o_mult_mc    <= '0;
        end else begin
            // Pulse outputs are raised only on the edge entering their
            // one-cycle state, so clearing them by default gives single pulses.
            o_ack        <= '0;
            o_done       <= '0;
            o_err        <= '0;
            o_mult_start <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (|i_req) begin
                        state        <= S_START;
                        o_owner      <= grant;
                        last_grant   <= grant;
                        o_mult_mp    <= grant ? i_mp1 : i_mp0;
                        o_mult_mc    <= grant ? i_mc1 : i_mc0;
                        o_ack        <= onehot(grant);
                        o_mult_start <= 1'b1;
                        o_busy       <= 1'b1;
                        cnt          <= '0;
                    end
                end

                S_START: begin
                    state <= S_WAIT_BUSY;
                end

                S_WAIT_BUSY: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (timeout_hit) begin
                        state <= S_ERR;
                        o_err <= onehot(o_owner);
                    end else if (!i_mult_rdy) begin
                        state <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                    // Timeout wins over a completion seen in the same cycle.
                    if (timeout_hit) begin
                        state <= S_ERR;
                        o_err <= onehot(o_owner);
                    end else if (i_mult_rdy) begin
                        state     <= S_DONE;
                        o_done    <= onehot(o_owner);
                        o_product <= i_mult_product;
                    end
                end

                S_DONE, S_ERR: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end

                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
